// File: rtl/wb_io_pkg.sv
// Shared definitions for the J1 I/O register block: register offsets,
// STATUS bit positions and the timer reset constants.
// Imported by io_timer and wb_io_regs.
package wb_io_pkg;

  // Word offsets decoded from the low address bits.
  typedef enum logic [2:0] {
    REG_LED       = 3'd0,
    REG_SW        = 3'd1,
    REG_TIMER     = 3'd2,
    REG_TIMER_CMP = 3'd3,
    REG_STATUS    = 3'd4,
    REG_IRQ_EN    = 3'd5,
    REG_RSVD6     = 3'd6,
    REG_RSVD7     = 3'd7
  } reg_off_e;

  // STATUS / IRQ_EN bit positions.
  localparam int ST_TMATCH = 0;
  localparam int ST_SWCHG  = 1;
  localparam int ST_W      = 2;

  // The timer is a fixed 16-bit counter matching the J1 cell width.
  localparam int            TW            = 16;
  localparam logic [TW-1:0] TIMER_CMP_RST = 16'hFFFF;

endpackage

// File: rtl/if_wb.sv
// Wishbone B4 pipelined-mode bus bundle.
// Ports: adr/cyc/stb/we/dat_i from the master; dat_o/ack/stall from the slave.
// dat_i carries write data into the slave, dat_o carries read data out.
interface if_wb #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] adr;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [DW-1:0] dat_i;
  logic [DW-1:0] dat_o;
  logic          ack;
  logic          stall;

  modport slave (
    input  adr, cyc, stb, we, dat_i,
    output dat_o, ack, stall
  );

  modport master (
    output adr, cyc, stb, we, dat_i,
    input  dat_o, ack, stall
  );
endinterface

// File: rtl/io_timer.sv
// Purpose : prescaled free-running 16-bit timer with a compare register.
// Latency : TIMER/CMP update at the clock edge; match_o is combinational
//           and flags the edge on which TIMER will step onto CMP.
// Ports   : clk, reset (sync, active-high); wr_cmp_i/cmp_data_i load CMP;
//           timer_o/cmp_o current values; match_o increment-lands-on-CMP.
module io_timer
  import wb_io_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_cmp_i,
  input  logic [TW-1:0] cmp_data_i,
  output logic [TW-1:0] timer_o,
  output logic [TW-1:0] cmp_o,
  output logic          match_o
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] cmp_q, cmp_d;
  logic [TW-1:0] timer_inc;
  logic          tick;

  // With PRESCALE=1 the prescaler sits at 0 and every cycle is a tick.
  assign tick      = (pre_q == PRE_LAST);
  assign timer_inc = timer_q + TW'(1);

  always_comb begin
    pre_d   = tick ? '0 : pre_q + PW'(1);
    timer_d = tick ? timer_inc : timer_q;
    cmp_d   = wr_cmp_i ? cmp_data_i : cmp_q;
  end

  // Compared against the CMP value held before the edge, so loading CMP with
  // the current TIMER value never raises a match by itself.
  assign match_o = tick & (timer_inc == cmp_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      timer_q <= '0;
      cmp_q   <= TIMER_CMP_RST;
    end else begin
      pre_q   <= pre_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
    end
  end

  assign timer_o = timer_q;
  assign cmp_o   = cmp_q;

endmodule

// File: rtl/wb_io_regs.sv
// Purpose : Wishbone B4 pipelined I/O register slave (LED, SW, timer, STATUS/IRQ).
// Latency : ack and read data one cycle after accept; back-to-back at WAIT_STATES=0.
// Backpres: stall held for WAIT_STATES cycles of each request; dropping cyc clears it.
// Ports   : clk, reset (sync, active-high); wb slave modport; sw async switch
//           inputs; led register; irq = registered |(STATUS & IRQ_EN).
module wb_io_regs
  import wb_io_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int RAW         = 3,
  parameter int LED_W       = 8,
  parameter int SW_W        = 8,
  parameter int PRESCALE    = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             reset,
  if_wb.slave              wb,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  // Bus handshake
  logic           req;
  logic           stall;
  logic           accept;
  logic           wr;
  logic [RAW-1:0] off;
  logic [3:0]     wcnt_q, wcnt_d;
  logic           ack_q;
  logic [DW-1:0]  dat_q, dat_d;
  logic [DW-1:0]  rd_data;

  // Register state
  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q, sw_prev_q;
  logic [ST_W-1:0]  status_q, status_d;
  logic [ST_W-1:0]  st_set, st_clr;
  logic [1:0]       irq_en_q, irq_en_d;
  logic             irq_q;

  // Timer
  logic [TW-1:0] timer;
  logic [TW-1:0] cmp;
  logic          tmatch;
  logic          wr_cmp;

  logic unused_adr;
  assign unused_adr = ^wb.adr[AW-1:RAW];

  assign req    = wb.cyc & wb.stb;
  assign off    = wb.adr[RAW-1:0];
  assign accept = req & ~stall;
  assign wr     = accept & wb.we;
  assign wr_cmp = wr & (off == RAW'(REG_TIMER_CMP));

  if (WAIT_STATES == 0) begin : g_nowait
    assign stall = 1'b0;
  end else begin : g_wait
    assign stall = req & (wcnt_q < 4'(WAIT_STATES));
  end

  // Wait counter restarts for every new request and whenever the master
  // withdraws, so a dropped request leaves nothing behind.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!req || accept) begin
      wcnt_d = '0;
    end else if (stall) begin
      wcnt_d = wcnt_q + 4'd1;
    end
  end

  // Read mux: values as they stand before the accepting edge.
  always_comb begin
    rd_data = '0;
    case (off)
      RAW'(REG_LED):       rd_data = DW'(led_q);
      RAW'(REG_SW):        rd_data = DW'(sw_sync_q);
      RAW'(REG_TIMER):     rd_data = DW'(timer);
      RAW'(REG_TIMER_CMP): rd_data = DW'(cmp);
      RAW'(REG_STATUS):    rd_data = DW'(status_q);
      RAW'(REG_IRQ_EN):    rd_data = DW'(irq_en_q);
      default:             rd_data = '0;
    endcase
  end

  // dat_o is only non-zero in the ack cycle of a read.
  assign dat_d = (accept && !wb.we) ? rd_data : '0;

  always_comb begin
    led_d    = led_q;
    irq_en_d = irq_en_q;
    if (wr && off == RAW'(REG_LED)) begin
      led_d = wb.dat_i[LED_W-1:0];
    end
    if (wr && off == RAW'(REG_IRQ_EN)) begin
      irq_en_d = wb.dat_i[1:0];
    end
  end

  // STATUS is write-1-to-clear; a new event in the same cycle as its clear
  // takes priority so the event is never lost.
  always_comb begin
    st_set            = '0;
    st_set[ST_TMATCH] = tmatch;
    st_set[ST_SWCHG]  = (sw_sync_q != sw_prev_q);
    st_clr            = (wr && off == RAW'(REG_STATUS)) ? wb.dat_i[ST_W-1:0] : '0;
    status_d          = (status_q & ~st_clr) | st_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q    <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      sw_prev_q <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      ack_q     <= accept;
      dat_q     <= dat_d;
      led_q     <= led_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      sw_prev_q <= sw_sync_q;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= |(status_q & irq_en_q);
    end
  end

  io_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .wr_cmp_i   (wr_cmp),
    .cmp_data_i (wb.dat_i[TW-1:0]),
    .timer_o    (timer),
    .cmp_o      (cmp),
    .match_o    (tmatch)
  );

  assign wb.ack   = ack_q;
  assign wb.dat_o = dat_q;
  assign wb.stall = stall;
  assign led      = led_q;
  assign irq      = irq_q;

endmodule
